// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: sequences memory operations against the memory stage,
// registers the final scalar/vector result and drives one-cycle register-file write enables.
module memwb_stage #(
  parameter int unsigned I = 20,
  parameter int unsigned L = 8,
  parameter int unsigned R = 5,
  parameter int unsigned T = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             mem_op_i,
  input  logic [1:0]       op_type_i,
  input  logic             wb_en_i,
  input  logic             wb_sel_i,
  input  logic [R-1:0]     rd_i,
  input  logic [L-1:0]     aluResultS_i,
  input  logic [I*L-1:0]   aluResultV_i,
  input  logic [L-1:0]     scalar_mem_i,
  input  logic [I*L-1:0]   vector_mem_i,
  input  logic             mem_finished_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             mem_rst_o,
  output logic             wb_valid_o,
  output logic             we_sca_o,
  output logic             we_vec_o,
  output logic [R-1:0]     wa_o,
  output logic [L-1:0]     wd_sca_o,
  output logic [I*L-1:0]   wd_vec_o,
  output logic             mem_timeout_o
);

  localparam int unsigned CW = $clog2(T + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic             we_sca_q, we_sca_d;
  logic             we_vec_q, we_vec_d;
  logic [R-1:0]     wa_q, wa_d;
  logic [L-1:0]     wd_sca_q, wd_sca_d;
  logic [I*L-1:0]   wd_vec_q, wd_vec_d;
  logic             timeout_q, timeout_d;
  logic             capture;
  logic             stall;
  logic             mem_rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    stall     = 1'b0;
    mem_rst   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // mem_finished_i is deliberately ignored here: a stale done flag must not retire a new op
        if (valid_i && !flush_i) begin
          if (mem_op_i) begin
            mem_rst = 1'b1;
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            capture = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_finished_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(T - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = capture;
    we_vec_d   = capture & wb_en_i & op_type_i[1];
    we_sca_d   = capture & wb_en_i & ~op_type_i[1] & op_type_i[0];
    wa_d       = capture ? rd_i : wa_q;
    wd_sca_d   = wd_sca_q;
    wd_vec_d   = wd_vec_q;
    if (capture) begin
      wd_sca_d = wb_sel_i ? scalar_mem_i : aluResultS_i;
      wd_vec_d = wb_sel_i ? vector_mem_i : aluResultV_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      we_sca_q   <= 1'b0;
      we_vec_q   <= 1'b0;
      wa_q       <= '0;
      wd_sca_q   <= '0;
      wd_vec_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      we_sca_q   <= we_sca_d;
      we_vec_q   <= we_vec_d;
      wa_q       <= wa_d;
      wd_sca_q   <= wd_sca_d;
      wd_vec_q   <= wd_vec_d;
      timeout_q  <= timeout_d;
    end
  end

  // Handshake outputs are held low while reset is asserted so every output reads 0 in reset.
  assign stall_o       = stall & ~rst;
  assign mem_rst_o     = mem_rst & ~rst;
  assign wb_valid_o    = wb_valid_q;
  assign we_sca_o      = we_sca_q;
  assign we_vec_o      = we_vec_q;
  assign wa_o          = wa_q;
  assign wd_sca_o      = wd_sca_q;
  assign wd_vec_o      = wd_vec_q;
  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: table of single-cycle ALU retirements plus
// hand-written memory sequences (load, store/load, flush, watchdog, reset mid-wait).
module tb_memwb_stage;

  localparam int unsigned I  = 20;
  localparam int unsigned L  = 8;
  localparam int unsigned R  = 5;
  localparam int unsigned T  = 8;
  localparam int unsigned VW = I * L;

  localparam logic [VW-1:0] V0 = {20{8'h01}};
  localparam logic [VW-1:0] V1 = {20{8'h2C}};
  localparam logic [VW-1:0] M0 = {20{8'hE7}};
  localparam logic [VW-1:0] M1 = {10{16'hBEEF}};
  localparam logic [VW-1:0] M2 = {5{32'h1234_5678}};

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i, mem_op_i, wb_en_i, wb_sel_i, mem_finished_i, flush_i;
  logic [1:0]    op_type_i;
  logic [R-1:0]  rd_i;
  logic [L-1:0]  aluResultS_i, scalar_mem_i;
  logic [VW-1:0] aluResultV_i, vector_mem_i;
  logic          stall_o, mem_rst_o, wb_valid_o, we_sca_o, we_vec_o, mem_timeout_o;
  logic [R-1:0]  wa_o;
  logic [L-1:0]  wd_sca_o;
  logic [VW-1:0] wd_vec_o;

  int ncmp = 0;
  int nerr = 0;

  memwb_stage #(.I(I), .L(L), .R(R), .T(T)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .op_type_i(op_type_i), .wb_en_i(wb_en_i), .wb_sel_i(wb_sel_i), .rd_i(rd_i),
    .aluResultS_i(aluResultS_i), .aluResultV_i(aluResultV_i),
    .scalar_mem_i(scalar_mem_i), .vector_mem_i(vector_mem_i),
    .mem_finished_i(mem_finished_i), .flush_i(flush_i),
    .stall_o(stall_o), .mem_rst_o(mem_rst_o), .wb_valid_o(wb_valid_o),
    .we_sca_o(we_sca_o), .we_vec_o(we_vec_o), .wa_o(wa_o),
    .wd_sca_o(wd_sca_o), .wd_vec_o(wd_vec_o), .mem_timeout_o(mem_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic          en;
    logic          sel;
    logic [R-1:0]  rd;
    logic [L-1:0]  alus;
    logic [L-1:0]  scam;
    logic [VW-1:0] aluv;
    logic [VW-1:0] vecm;
    logic          e_sca;
    logic          e_vec;
    logic [R-1:0]  e_wa;
    logic [L-1:0]  e_wds;
    logic [VW-1:0] e_wdv;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic mop, input logic [1:0] op, input logic en, input logic sel,
                        input logic [R-1:0] rd, input logic [L-1:0] alus, input logic [L-1:0] scam,
                        input logic [VW-1:0] aluv, input logic [VW-1:0] vecm);
    valid_i = 1'b1; mem_op_i = mop; op_type_i = op; wb_en_i = en; wb_sel_i = sel;
    rd_i = rd; aluResultS_i = alus; scalar_mem_i = scam;
    aluResultV_i = aluv; vector_mem_i = vecm;
  endtask

  // Runs a memory request already driven on the inputs until stall_o drops.
  // Cycle 0 is the request cycle; done/flush/reset are asserted in the given cycle (-1 = never).
  task automatic mem_seq(input int done_at, input bit fin_hold, input int flush_at, input int rst_at,
                         output int stalls, output int rsts);
    bit left = 1'b0;
    stalls = 0;
    rsts   = 0;
    for (int c = 0; c < 40 && !left; c++) begin
      mem_finished_i = fin_hold || (c == done_at);
      flush_i        = (c == flush_at);
      rst            = (c == rst_at);
      #1;
      if (stall_o)   stalls++;
      if (mem_rst_o) rsts++;
      left = !stall_o;
      step();
    end
    flush_i = 1'b0;
    rst     = 1'b0;
    valid_i = 1'b0;
    mem_finished_i = fin_hold;
    chk("seq_bound", {31'd0, left}, 1);
  endtask

  int st, rs;

  initial begin
    vecs[0] = '{2'b01, 1'b1, 1'b0, 5'd3,  8'h5A, 8'h11, V0, M0, 1'b1, 1'b0, 5'd3,  8'h5A, V0};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 5'd9,  8'h22, 8'h11, V1, M0, 1'b0, 1'b1, 5'd9,  8'h22, V1};
    vecs[2] = '{2'b11, 1'b1, 1'b1, 5'd31, 8'h33, 8'hC4, V0, M1, 1'b0, 1'b1, 5'd31, 8'hC4, M1};
    vecs[3] = '{2'b01, 1'b0, 1'b1, 5'd0,  8'h44, 8'h7E, V1, M0, 1'b0, 1'b0, 5'd0,  8'h7E, M0};
    vecs[4] = '{2'b00, 1'b1, 1'b0, 5'd17, 8'hFF, 8'h00, V1, M1, 1'b0, 1'b0, 5'd17, 8'hFF, V1};

    rst = 1'b1; valid_i = 1'b0; mem_op_i = 1'b0; op_type_i = 2'b00; wb_en_i = 1'b0;
    wb_sel_i = 1'b0; rd_i = '0; aluResultS_i = '0; aluResultV_i = '0;
    scalar_mem_i = '0; vector_mem_i = '0; mem_finished_i = 1'b0; flush_i = 1'b0;

    step(); step();
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_rst", mem_rst_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_we_sca", we_sca_o, 0);
    chk("rst_we_vec", we_vec_o, 0);
    chk("rst_wa", wa_o, 0);
    chk("rst_wd_sca", wd_sca_o, 0);
    chk("rst_wd_vec", wd_vec_o, 0);
    chk("rst_timeout", mem_timeout_o, 0);
    rst = 1'b0;

    // Back-to-back ALU ops, one retirement per cycle.
    for (int k = 0; k < 5; k++) begin
      set_op(1'b0, vecs[k].op, vecs[k].en, vecs[k].sel, vecs[k].rd, vecs[k].alus,
             vecs[k].scam, vecs[k].aluv, vecs[k].vecm);
      #1;
      chk("alu_stall", stall_o, 0);
      chk("alu_mem_rst", mem_rst_o, 0);
      step();
      chk("alu_wb_valid", wb_valid_o, 1);
      chk("alu_we_sca", we_sca_o, vecs[k].e_sca);
      chk("alu_we_vec", we_vec_o, vecs[k].e_vec);
      chk("alu_wa", wa_o, vecs[k].e_wa);
      chk("alu_wd_sca", wd_sca_o, vecs[k].e_wds);
      chk("alu_wd_vec", wd_vec_o, vecs[k].e_wdv);
    end
    valid_i = 1'b0;
    step();
    chk("idle_wb_valid", wb_valid_o, 0);
    chk("idle_we_sca", we_sca_o, 0);
    chk("idle_we_vec", we_vec_o, 0);
    chk("idle_wa_hold", wa_o, 17);
    chk("idle_wd_sca_hold", wd_sca_o, 8'hFF);

    // Vector load, done seen in the 4th cycle after the request.
    set_op(1'b1, 2'b10, 1'b1, 1'b1, 5'd7, 8'h01, 8'h02, V0, M2);
    mem_seq(4, 1'b0, -1, -1, st, rs);
    chk("vld_stalls", st, 4);
    chk("vld_mem_rst", rs, 1);
    chk("vld_wb_valid", wb_valid_o, 1);
    chk("vld_we_vec", we_vec_o, 1);
    chk("vld_we_sca", we_sca_o, 0);
    chk("vld_wa", wa_o, 7);
    chk("vld_wd_vec", wd_vec_o, M2);
    step();
    chk("vld_wb_valid_drop", wb_valid_o, 0);

    // Store then load with mem_finished_i held high throughout.
    set_op(1'b1, 2'b00, 1'b0, 1'b1, 5'd4, 8'h10, 8'h20, V0, M0);
    mem_seq(-1, 1'b1, -1, -1, st, rs);
    chk("st_stalls", st, 1);
    chk("st_mem_rst", rs, 1);
    chk("st_wb_valid", wb_valid_o, 1);
    chk("st_we_sca", we_sca_o, 0);
    chk("st_we_vec", we_vec_o, 0);
    set_op(1'b1, 2'b01, 1'b1, 1'b1, 5'd5, 8'h10, 8'h9C, V0, M0);
    mem_seq(-1, 1'b1, -1, -1, st, rs);
    chk("ld_stalls", st, 1);
    chk("ld_mem_rst", rs, 1);
    chk("ld_we_sca", we_sca_o, 1);
    chk("ld_wa", wa_o, 5);
    chk("ld_wd_sca", wd_sca_o, 8'h9C);
    mem_finished_i = 1'b0;

    // Flush in the 2nd WAIT cycle, then a normal ALU op.
    set_op(1'b1, 2'b01, 1'b1, 1'b1, 5'd8, 8'h10, 8'hAB, V0, M0);
    mem_seq(-1, 1'b0, 2, -1, st, rs);
    chk("fl_stalls", st, 2);
    chk("fl_wb_valid", wb_valid_o, 0);
    chk("fl_we_sca", we_sca_o, 0);
    chk("fl_wa_hold", wa_o, 5);
    set_op(1'b0, 2'b01, 1'b1, 1'b0, 5'd12, 8'h6B, 8'h00, V1, M0);
    #1;
    chk("fl_alu_stall", stall_o, 0);
    step();
    valid_i = 1'b0;
    chk("fl_alu_we_sca", we_sca_o, 1);
    chk("fl_alu_wa", wa_o, 12);
    chk("fl_alu_wd_sca", wd_sca_o, 8'h6B);

    // Flush on an IDLE memory request: no restart, no stall.
    set_op(1'b1, 2'b01, 1'b1, 1'b0, 5'd2, 8'h10, 8'h00, V0, M0);
    flush_i = 1'b1;
    #1;
    chk("fli_mem_rst", mem_rst_o, 0);
    chk("fli_stall", stall_o, 0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fli_wb_valid", wb_valid_o, 0);

    // Watchdog: done never arrives.
    set_op(1'b1, 2'b10, 1'b1, 1'b1, 5'd6, 8'h10, 8'h00, V0, M1);
    mem_seq(-1, 1'b0, -1, -1, st, rs);
    chk("wd_stalls", st, 8);
    chk("wd_timeout", mem_timeout_o, 1);
    chk("wd_wb_valid", wb_valid_o, 0);
    chk("wd_we_vec", we_vec_o, 0);
    step();
    chk("wd_sticky", mem_timeout_o, 1);
    chk("wd_stall_idle", stall_o, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wd_rst_clear", mem_timeout_o, 0);

    // Reset asserted in the 3rd stall cycle.
    set_op(1'b1, 2'b01, 1'b1, 1'b1, 5'd9, 8'h10, 8'h55, V0, M0);
    mem_seq(-1, 1'b0, -1, 2, st, rs);
    chk("rw_stalls", st, 2);
    chk("rw_wb_valid", wb_valid_o, 0);
    chk("rw_stall_after", stall_o, 0);
    set_op(1'b0, 2'b01, 1'b1, 1'b0, 5'd1, 8'h3C, 8'h00, V0, M0);
    #1;
    chk("rw_idle_stall", stall_o, 0);
    step();
    valid_i = 1'b0;
    chk("rw_alu_we_sca", we_sca_o, 1);
    chk("rw_alu_wd_sca", wd_sca_o, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
# memwb_stage

Pipeline stage directly downstream of the memory stage. Accepts one instruction per cycle from the EX/MEM boundary, sequences memory operations by stalling upstream until the memory stage reports `mem_finished`, and issues a per-operation restart pulse to the memory stage. It registers the final scalar or vector result and the destination index, then drives one-cycle write enables into the register file.

## Interface
Parameters:
- `I`, 20, items per vector
- `L`, 8, item width in bits
- `R`, 5, register index width
- `T`, 255, watchdog limit in cycles for a single memory operation (at least 2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  1  upstream instruction valid
- `mem_op_i`  in  1  instruction uses the memory stage (load or store)
- `op_type_i`  in  2  bit1 = vector destination, bit0 = scalar destination; bit1 takes priority
- `wb_en_i`  in  1  instruction writes the register file
- `wb_sel_i`  in  1  1 = memory data, 0 = ALU result
- `rd_i`  in  R  destination register index
- `aluResultS_i`  in  L  scalar ALU result
- `aluResultV_i`  in  I*L  vector ALU result
- `scalar_mem_i`  in  L  memory stage `scalar_output`
- `vector_mem_i`  in  I*L  memory stage `vector_output`
- `mem_finished_i`  in  1  memory stage done flag
- `flush_i`  in  1  kill the in-flight instruction
- `stall_o`  out  1  upstream must hold all inputs stable
- `mem_rst_o`  out  1  one-cycle restart pulse, ORed into the memory stage `rst`
- `wb_valid_o`  out  1  registered result valid, one cycle per retired instruction
- `we_sca_o`  out  1  scalar register-file write enable
- `we_vec_o`  out  1  vector register-file write enable
- `wa_o`  out  R  write address
- `wd_sca_o`  out  L  scalar write data
- `wd_vec_o`  out  I*L  vector write data
- `mem_timeout_o`  out  1  sticky watchdog error

## Operation
- FSM states: `IDLE`, `WAIT`.
- **`IDLE`, `valid_i & ~mem_op_i`:** capture the result. `stall_o` = 0.
- **`IDLE`, `valid_i & mem_op_i`:**
  - `mem_rst_o` = 1 and `stall_o` = 1 (both combinational).
  - Clear the watchdog counter and go to `WAIT`.
  - `mem_finished_i` is ignored in `IDLE`, because a stale done flag from the previous operation must not retire a new one.
- **`WAIT`:**
  - `stall_o` = `~mem_finished_i` and `mem_rst_o` = 0.
  - The counter increments each cycle.
  - When `mem_finished_i` = 1: capture the result and return to `IDLE`.
- **Capture:** registered on the same edge.
  - `wd_sca_o` = `wb_sel_i ? scalar_mem_i : aluResultS_i`.
  - `wd_vec_o` = `wb_sel_i ? vector_mem_i : aluResultV_i`.
  - `wa_o` = `rd_i`.
  - `wb_valid_o` = 1.
  - `we_vec_o` = `wb_en_i & op_type_i[1]`.
  - `we_sca_o` = `wb_en_i & ~op_type_i[1] & op_type_i[0]`.
- **Stores:** `wb_en_i` = 0, so `wb_valid_o` pulses with both write enables at 0.
- **Outputs with no capture:** `wb_valid_o`, `we_sca_o` and `we_vec_o` return to 0. `wa_o`, `wd_sca_o` and `wd_vec_o` hold their last values.
- **Watchdog:** if the counter reaches `T` in `WAIT` without done:
  - Set `mem_timeout_o` (sticky until `rst`).
  - Abort without writeback and go to `IDLE`. `stall_o` = 0 in that cycle.
- **`flush_i`:**
  - In `WAIT`: go to `IDLE` with no capture, `stall_o` = 0. Flush has priority over `mem_finished_i` and the watchdog.
  - In `IDLE`: suppress capture and suppress `mem_rst_o`.
- **Invalid input:** `valid_i` = 0 in `IDLE` does nothing, and all other inputs are don't-care.

## Timing
- **Reset:** state `IDLE`, counter 0. Every output is 0 at reset: `stall_o`, `mem_rst_o`, `wb_valid_o`, `we_sca_o`, `we_vec_o`, `wa_o`, `wd_sca_o`, `wd_vec_o`, `mem_timeout_o`.
- **Reset mid-`WAIT`:** returns to `IDLE` next edge; no writeback; watchdog error cleared.
- **Non-memory latency:** 1 cycle (input in cycle n, `wb_valid_o` in n+1). Sustained throughput is 1 per cycle.
- **Memory latency:**
  - Request in cycle n with `mem_rst_o` and `stall_o` high; `WAIT` starts in n+1.
  - If done is first seen in cycle m > n, `wb_valid_o` is high in m+1 and `stall_o` is low in m.
  - Minimum total is 2 cycles plus 1 for writeback.
- **Upstream handshake:** upstream advances only on an edge where `stall_o` = 0.
- **Back-to-back memory ops:** the second request is seen in `IDLE` at m+1 and restarts the memory stage, even if `mem_finished_i` is still high.
- **Combinational paths:** `stall_o` and `mem_rst_o` depend combinationally on `valid_i`, `mem_op_i`, `flush_i`, `mem_finished_i` and state. All other outputs are registered.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0. Then an ALU op (`rd_i`=3, `aluResultS_i`=0x5A, `op_type_i`=01, `wb_en_i`=1) → next cycle `we_sca_o`=1, `wa_o`=3, `wd_sca_o`=0x5A, `stall_o` never high.
- **Vector load, 4-cycle done:** `rd_i`=7, `wb_sel_i`=1, `op_type_i`=10, done after 4 cycles → `mem_rst_o` pulses once, `stall_o` high exactly 4 cycles, then `we_vec_o`=1 with `wd_vec_o`=`vector_mem_i`.
- **Store then load with `mem_finished_i` held high throughout:** store retires with `wb_valid_o`=1 and both enables 0. The load still gets a `mem_rst_o` pulse and stalls at least 1 cycle.
- **Flush in the 2nd `WAIT` cycle:** no write enable; `stall_o` low the same cycle; the next ALU op retires normally.
- **Watchdog (`T`=8, done never asserted):** `mem_timeout_o` rises after 8 `WAIT` cycles and stays high; no writeback; `stall_o` low. `rst` clears it.
- **Reset mid-`WAIT`:** `rst` in 3rd stall cycle → `IDLE`, `stall_o`=0, no writeback.
